// File: rtl/alu_seq.sv
// Multi-cycle unsigned ALU: single-cycle add/sub, shift-add multiply and restoring divide.
// Results are registered and held until the next completion.
module alu_seq #(
    parameter int unsigned WIDTH = 3
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_init,
    input  logic [WIDTH-1:0]   i_a,
    input  logic [WIDTH-1:0]   i_b,
    input  logic [1:0]         i_op,
    output logic [2*WIDTH-1:0] o_out_op,
    output logic               o_done,
    output logic               o_busy,
    output logic               o_err
);

    localparam int unsigned CW = $clog2(WIDTH + 1);
    localparam int unsigned RW = 2 * WIDTH;

    typedef enum logic [1:0] {StIdle, StMul, StDiv, StDone} state_e;

    state_e           r_state;
    state_e           w_state_next;
    logic [CW-1:0]    r_cnt;
    logic [RW-1:0]    r_acc;
    logic [RW-1:0]    r_mcand;
    logic [WIDTH-1:0] r_mplr;
    logic [WIDTH-1:0] r_dvd;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_b;
    logic [RW-1:0]    r_out;
    logic             r_err;

    logic             w_last;
    logic [RW-1:0]    w_mul_acc;
    logic [WIDTH:0]   w_div_shift;
    logic             w_div_ok;
    logic [WIDTH-1:0] w_rem_next;
    logic [WIDTH-1:0] w_quo_next;

    assign w_last    = (r_cnt == CW'(1));
    assign w_mul_acc = r_mplr[0] ? (r_acc + r_mcand) : r_acc;

    // r_dvd shifts dividend bits out of its MSB while quotient bits enter at its LSB.
    assign w_div_shift = {r_rem, r_dvd[WIDTH-1]};
    assign w_div_ok    = (w_div_shift >= {1'b0, r_b});
    assign w_rem_next  = w_div_ok ? (w_div_shift[WIDTH-1:0] - r_b) : w_div_shift[WIDTH-1:0];
    assign w_quo_next  = {r_dvd[WIDTH-2:0], w_div_ok};

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle: begin
                if (i_init) begin
                    unique case (i_op)
                        2'b10:   w_state_next = StMul;
                        2'b11:   w_state_next = (i_b == '0) ? StDone : StDiv;
                        default: w_state_next = StDone;
                    endcase
                end
            end
            StMul:   if (w_last) w_state_next = StDone;
            StDiv:   if (w_last) w_state_next = StDone;
            StDone:  w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_cnt   <= '0;
            r_acc   <= '0;
            r_mcand <= '0;
            r_mplr  <= '0;
            r_dvd   <= '0;
            r_rem   <= '0;
            r_b     <= '0;
            r_out   <= '0;
            r_err   <= 1'b0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (i_init) begin
                        r_cnt   <= CW'(WIDTH);
                        r_acc   <= '0;
                        r_mcand <= RW'(i_a);
                        r_mplr  <= i_b;
                        r_dvd   <= i_a;
                        r_rem   <= '0;
                        r_b     <= i_b;
                        unique case (i_op)
                            2'b00: begin
                                r_out <= RW'(i_a) + RW'(i_b);
                                r_err <= 1'b0;
                            end
                            2'b01: begin
                                r_out <= RW'(i_a) - RW'(i_b);
                                r_err <= 1'b0;
                            end
                            2'b10: ;
                            2'b11: begin
                                if (i_b == '0) begin
                                    r_out <= '1;
                                    r_err <= 1'b1;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                StMul: begin
                    r_cnt   <= r_cnt - CW'(1);
                    r_acc   <= w_mul_acc;
                    r_mcand <= r_mcand << 1;
                    r_mplr  <= r_mplr >> 1;
                    if (w_last) begin
                        r_out <= w_mul_acc;
                        r_err <= 1'b0;
                    end
                end
                StDiv: begin
                    r_cnt <= r_cnt - CW'(1);
                    r_rem <= w_rem_next;
                    r_dvd <= w_quo_next;
                    if (w_last) begin
                        r_out <= {w_rem_next, w_quo_next};
                        r_err <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_out_op = r_out;
    assign o_err    = r_err;
    assign o_done   = (r_state == StDone);
    assign o_busy   = (r_state != StIdle);

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: WIDTH=3 and WIDTH=8 instances, table vectors, random ops and
// hand-written abort/ignore sequences checked through an expected-result queue.
module tb_alu_seq;

    logic       clk;
    logic       rst_n;
    logic       init3, init8;
    logic [2:0] a3, b3;
    logic [7:0] a8, b8;
    logic [1:0] op3, op8;
    logic [5:0] out3;
    logic [15:0] out8;
    logic       done3, busy3, err3, done8, busy8, err8;

    alu_seq #(.WIDTH(3)) u_dut3 (
        .i_clk(clk), .i_rst_n(rst_n), .i_init(init3), .i_a(a3), .i_b(b3), .i_op(op3),
        .o_out_op(out3), .o_done(done3), .o_busy(busy3), .o_err(err3)
    );

    alu_seq #(.WIDTH(8)) u_dut8 (
        .i_clk(clk), .i_rst_n(rst_n), .i_init(init8), .i_a(a8), .i_b(b8), .i_op(op8),
        .o_out_op(out8), .o_done(done8), .o_busy(busy8), .o_err(err8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_err = 0;

    logic sel8 = 1'b0;
    wire [15:0] s_out  = sel8 ? out8 : {10'b0, out3};
    wire        s_done = sel8 ? done8 : done3;
    wire        s_busy = sel8 ? busy8 : busy3;
    wire        s_err  = sel8 ? err8 : err3;

    typedef struct {
        logic [15:0] out;
        logic        err;
        int          due;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        logic [1:0]  op;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] out;
        logic        err;
        int          lat;
    } vec_t;
    vec_t tbl[11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic drive(input logic [7:0] a, input logic [7:0] b, input logic [1:0] op,
                         input logic go);
        if (sel8) begin
            a8 = a; b8 = b; op8 = op; init8 = go;
        end else begin
            a3 = a[2:0]; b3 = b[2:0]; op3 = op; init3 = go;
        end
    endtask

    function automatic logic [31:0] model(input int w, input logic [1:0] op, input int a,
                                          input int b);
        logic [31:0] mask;
        mask = (32'd1 << (2 * w)) - 32'd1;
        case (op)
            2'd0:    return 32'(a + b) & mask;
            2'd1:    return 32'(a - b) & mask;
            2'd2:    return 32'(a * b) & mask;
            default: return (b == 0) ? mask : ((32'(a % b) << w) | 32'(a / b));
        endcase
    endfunction

    // poke >= 0 pulses init with unrelated operands that many cycles into the operation.
    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic [1:0] op,
                          input logic [15:0] eout, input logic eerr, input int lat,
                          input int poke);
        exp_t e;
        bit   got;
        bit   busy_ok;
        @(negedge clk);
        drive(a, b, op, 1'b1);
        e.out = eout;
        e.err = eerr;
        e.due = cyc + lat;
        sb.push_back(e);
        @(negedge clk);
        got     = 0;
        busy_ok = 1;
        for (int i = 0; i < 40 && !got; i++) begin
            drive(~a, ~b, ~op, (i == poke) ? 1'b1 : 1'b0);
            if (!s_busy) busy_ok = 0;
            if (s_done) begin
                got = 1;
                e = sb.pop_front();
                check("out_op", 32'(s_out), 32'(e.out));
                check("err", 32'(s_err), 32'(e.err));
                check("latency", cyc, e.due);
            end else begin
                @(negedge clk);
            end
        end
        if (!got) begin
            n_vec++;
            n_err++;
            $display("FAIL timeout: no done, expected out_op %0h", eout);
            sb.delete();
        end else begin
            check("busy", 32'(busy_ok), 32'd1);
            @(negedge clk);
            drive(~a, ~b, ~op, 1'b0);
            check("done_pulse", 32'(s_done), 32'd0);
            check("busy_idle", 32'(s_busy), 32'd0);
            check("hold", 32'(s_out), 32'(eout));
        end
    endtask

    initial begin
        int nd;
        logic [7:0] ra, rb;
        logic [1:0] rop;

        tbl[0]  = '{2'd0, 8'd2, 8'd5, 16'd7,  1'b0, 1};
        tbl[1]  = '{2'd1, 8'd2, 8'd5, 16'd61, 1'b0, 1};
        tbl[2]  = '{2'd0, 8'd7, 8'd7, 16'd14, 1'b0, 1};
        tbl[3]  = '{2'd1, 8'd0, 8'd7, 16'd57, 1'b0, 1};
        tbl[4]  = '{2'd2, 8'd7, 8'd7, 16'd49, 1'b0, 4};
        tbl[5]  = '{2'd2, 8'd2, 8'd5, 16'd10, 1'b0, 4};
        tbl[6]  = '{2'd2, 8'd0, 8'd5, 16'd0,  1'b0, 4};
        tbl[7]  = '{2'd3, 8'd7, 8'd2, 16'd11, 1'b0, 4};
        tbl[8]  = '{2'd3, 8'd2, 8'd5, 16'd16, 1'b0, 4};
        tbl[9]  = '{2'd3, 8'd6, 8'd3, 16'd2,  1'b0, 4};
        tbl[10] = '{2'd3, 8'd5, 8'd0, 16'd63, 1'b1, 1};

        rst_n = 1'b0;
        init3 = 1'b0; a3 = '0; b3 = '0; op3 = '0;
        init8 = 1'b0; a8 = '0; b8 = '0; op8 = '0;
        repeat (3) @(negedge clk);
        check("rst_out3", 32'(out3), 32'd0);
        check("rst_flags3", {29'd0, done3, busy3, err3}, 32'd0);
        check("rst_out8", 32'(out8), 32'd0);
        check("rst_flags8", {29'd0, done8, busy8, err8}, 32'd0);
        rst_n = 1'b1;

        sel8 = 1'b0;
        for (int i = 0; i < 11; i++) begin
            run_op(tbl[i].a, tbl[i].b, tbl[i].op, tbl[i].out, tbl[i].err, tbl[i].lat, -1);
        end

        // init mid-multiply is ignored; original product comes back
        run_op(8'd7, 8'd7, 2'd2, 16'd49, 1'b0, 4, 1);
        // init on the done cycle is ignored too
        run_op(8'd3, 8'd2, 2'd0, 16'd5, 1'b0, 1, 0);
        check("no_late_start", 32'(busy3), 32'd0);

        // reset during a multiply: err is 1 beforehand so a stale flag would show
        run_op(8'd5, 8'd0, 2'd3, 16'd63, 1'b1, 1, -1);
        @(negedge clk);
        drive(8'd3, 8'd3, 2'd2, 1'b1);
        @(negedge clk);
        drive(8'd0, 8'd0, 2'd0, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("abort_out", 32'(out3), 32'd0);
        check("abort_flags", {29'd0, done3, busy3, err3}, 32'd0);
        nd = 0;
        repeat (6) begin
            @(negedge clk);
            if (done3) nd++;
        end
        check("abort_no_done", nd, 0);
        run_op(8'd1, 8'd1, 2'd0, 16'd2, 1'b0, 1, -1);

        sel8 = 1'b1;
        for (int i = 0; i < 16; i++) begin
            rop = 2'(i % 4);
            ra  = 8'($urandom_range(0, 255));
            rb  = 8'($urandom_range(0, 255));
            if (rop == 2'd3 && rb == 8'd0) rb = 8'd1;
            run_op(ra, rb, rop, 16'(model(8, rop, int'(ra), int'(rb))), 1'b0,
                   (rop >= 2'd2) ? 9 : 1, -1);
        end
        run_op(8'd255, 8'd255, 2'd2, 16'd65025, 1'b0, 9, 3);
        run_op(8'd200, 8'd0, 2'd3, 16'hffff, 1'b1, 1, -1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised multi-cycle ALU, the successor of the 3-bit, 2-bit-opcode ALU. It takes two unsigned `WIDTH`-bit operands and a 2-bit opcode on an `init` pulse. Add and subtract complete in one cycle; multiply is shift-add and divide is restoring, one bit per cycle. It reports completion with a one-cycle `done` pulse and holds the result until the next operation. It sits beside the control FSM as its arithmetic unit, which polls `busy` and `done`.

## Interface
- `WIDTH`, default 3: operand width, legal range 2..16. The result is `2*WIDTH` bits.
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `init`  in  1  start pulse, sampled only in IDLE.
- `A`  in  WIDTH  operand A, unsigned.
- `B`  in  WIDTH  operand B, unsigned.
- `Op`  in  2  opcode: 00 add, 01 sub, 10 mul, 11 div.
- `out_op`  out  2*WIDTH  registered result.
- `done`  out  1  one-cycle pulse; `out_op` and `err` are valid with it.
- `busy`  out  1  high from the cycle after `init` is accepted until `done`, inclusive.
- `err`  out  1  divide-by-zero flag, updated with `done`.

## Operation
- **Reset** (`rst_n`=0 at a clock edge): state is IDLE; `out_op`=0, `done`=0, `busy`=0, `err`=0. Reset aborts any operation in progress, and no `done` is issued for it.
- **Operand capture:** `A`, `B` and `Op` are latched on the edge where `init`=1 in IDLE. After that, input changes have no effect until the next IDLE.
- **`init` while busy:** ignored, not queued.
- **States:** IDLE, MUL, DIV, DONE.
  - IDLE with `init`: add, sub and div-by-zero go to DONE. Mul goes to MUL with counter = `WIDTH`. Div with B≠0 goes to DIV with counter = `WIDTH`.
  - MUL / DIV: one iteration per cycle, counter decrements. Leaves for DONE on the cycle the counter goes 1→0.
  - DONE: `done`=1 and `busy`=1 for exactly one cycle, then IDLE. `init` in DONE is ignored.
- **Result formats:**
  - Add: `out_op` = zero-extended A+B; the carry lands in bit `WIDTH`.
  - Sub: `out_op` = 2*WIDTH-bit two's-complement A−B, sign-extended on borrow.
  - Mul: `out_op` = unsigned product, exact (no overflow possible).
  - Div: `out_op` = {remainder, quotient}, each `WIDTH` bits.
  - Div by zero: `out_op` = all ones, `err`=1.
- **`err`:** `err`=0 for every other completion. `err` holds its value until the next `done`.
- **Result hold:** `out_op` is written only on entry to DONE and holds through IDLE. Internal partial products and remainders must not appear on `out_op`.
- **Multiplier:** shift-add using a 2*WIDTH accumulator. Tests the LSB of the multiplier each cycle.
- **Divider:** restoring division. Shifts the remainder left by the next dividend MSB and subtracts B. Quotient bit is 1 if the result is non-negative, else the remainder is restored.

## Timing
- Let k be the edge where `init` is sampled in IDLE.
- **Add / sub / div-by-zero:** DONE in cycle k+1. `done`, `out_op` and `err` are valid after edge k+1. Latency is 1.
- **Mul / div:** `WIDTH` cycles in MUL/DIV, then DONE. `done` is high in cycle k+`WIDTH`+1. Latency is `WIDTH`+1.
- **Back-to-back:** earliest next accepted `init` is on the edge after DONE, i.e. edge k+2 for add. Throughput is one op per latency+1 cycles.
- **Reset timing:** `rst_n` low at an edge takes effect at that edge. Outputs are at reset values in the following cycle.

## Test plan
- WIDTH=3, A=2, B=5, Op=00, `init` pulse → `done` one cycle later, `out_op`=6'd7, `err`=0. Then Op=01 → `out_op`=6'b111101 (−3), latency 1.
- WIDTH=3, A=7, B=7, Op=10 → `done` exactly 4 cycles after `init`, `out_op`=6'd49. `busy` high for 4 cycles. A=2, B=5 → 6'd10.
- WIDTH=3, A=7, B=2, Op=11 → `out_op`=6'b001011 (r=1, q=3). A=2, B=5 → 6'b010000. Latency 4.
- WIDTH=3, A=5, B=0, Op=11 → `done` after 1 cycle, `out_op`=6'b111111, `err`=1. A following add 1+1 → `out_op`=2, `err`=0.
- Mul in progress: pulse `init` with new operands mid-operation → ignored, original product returned. Drop `rst_n` at cycle 2 of a mul → no `done`, all outputs 0, next op works normally.
- WIDTH=8: random A, B for all four ops (B≠0 for div) → matches the reference model. `done` at +1 for add/sub and +9 for mul/div.
